module_digit_scan: RTL

Parametrised digit-scan clock generator for the multiplexed 7-segment display path. It divides the 27 MHz system clock into a per-digit scan period, rotates a one-hot enable across N digit transistors, and inserts a programmable blanking (dead-time) window at every digit change to suppress ghosting. It also provides a square-wave `clk_out`, a one-cycle `tick` strobe per digit advance, and a runtime-reloadable divisor. It is the N-channel successor of the two-transistor divider.

---
 rtl/module_digit_scan.sv | 126 ++++++++++++
 1 files changed

// File: rtl/module_digit_scan.sv
// module_digit_scan
//
// Digit-scan clock generator for the multiplexed 7-segment display.
// The system clock is divided into one scan slot per digit. A one-hot
// enable walks across N_DIGITS digit transistors, and the first
// DEAD_CYCLES clocks of every slot are blanked so that the outgoing and
// incoming digits never overlap, which suppresses ghosting. The slot
// length can be reloaded at runtime. A reload is staged in a shadow
// register and takes over at a slot boundary, so a slot is never cut
// short or stretched.
//
// Ports:
//   clk        system clock, rising edge active
//   rst        synchronous active-high reset
//   en         count enable; low freezes the scan
//   div_load   one-cycle request to stage div_val as the next period
//   div_val    requested slot length in clocks (clamped to PMIN)
//   clk_out    square wave that toggles at every slot wrap
//   tick       one-cycle strobe on each digit advance
//   digit_sel  index of the current digit
//   dig_en     digit transistor drives, polarity set by ACTIVE_LOW
//   blank      high while every digit is forced off
module module_digit_scan #(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int SCAN_FREQ   = 1_000,
  parameter int N_DIGITS    = 4,
  parameter int DEAD_CYCLES = 270,
  parameter bit ACTIVE_LOW  = 1'b1,
  parameter int DEF_PERIOD  = CLK_FREQ / (2 * SCAN_FREQ)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        div_load,
  input  logic [24:0]                 div_val,
  output logic                        clk_out,
  output logic                        tick,
  output logic [$clog2(N_DIGITS)-1:0] digit_sel,
  output logic [N_DIGITS-1:0]         dig_en,
  output logic                        blank
);

  localparam int          SEL_W   = $clog2(N_DIGITS);
  localparam int          PMIN    = DEAD_CYCLES + 2;
  localparam logic [24:0] PMIN_V  = 25'(PMIN);
  localparam logic [24:0] DEF_V   = 25'(DEF_PERIOD);
  localparam logic [24:0] DEAD_V  = 25'(DEAD_CYCLES);
  localparam logic [SEL_W-1:0] LAST_DIGIT = SEL_W'(N_DIGITS - 1);

  // A reset period shorter than the blanking window plus two lit cycles
  // would leave no visible time per digit, so refuse to elaborate.
  if (DEF_PERIOD < PMIN) begin : g_bad_period
    $error("module_digit_scan: DEF_PERIOD must be at least DEAD_CYCLES+2");
  end
  if (N_DIGITS < 2) begin : g_bad_digits
    $error("module_digit_scan: N_DIGITS must be at least 2");
  end

  logic [24:0] count;
  logic [24:0] period;
  logic [24:0] shadow;
  logic        pend;
  logic        wrap;
  logic [24:0] load_val;

  // The slot ends on the last count of the active period.
  assign wrap = (count == period - 25'd1);

  // Requested periods below the minimum are raised to PMIN so that
  // every slot keeps at least two lit cycles after the blanking window.
  assign load_val = (div_val < PMIN_V) ? PMIN_V : div_val;

  // Main scan state. At a wrap a pending shadow value becomes the active
  // period for the slot just started. The load capture is written last
  // so that a request arriving on the wrap edge itself stays pending and
  // is applied one wrap later instead of being lost. Loads are captured
  // even while the scan is frozen.
  always_ff @(posedge clk) begin
    if (rst) begin
      count     <= '0;
      period    <= DEF_V;
      shadow    <= DEF_V;
      pend      <= 1'b0;
      digit_sel <= '0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
    end else begin
      if (en) begin
        if (wrap) begin
          count     <= '0;
          clk_out   <= ~clk_out;
          tick      <= 1'b1;
          digit_sel <= (digit_sel == LAST_DIGIT) ? '0 : digit_sel + 1'b1;
          if (pend) begin
            period <= shadow;
            pend   <= 1'b0;
          end
        end else begin
          count <= count + 25'd1;
          tick  <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
      if (div_load) begin
        shadow <= load_val;
        pend   <= 1'b1;
      end
    end
  end

  // Blanking covers the first DEAD_CYCLES counts of every slot.
  assign blank = (count < DEAD_V);

  // Only the selected digit may be lit, and only outside the blanking
  // window. Everything here decodes from registers alone.
  always_comb begin
    dig_en = ACTIVE_LOW ? '1 : '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (!blank && (digit_sel == SEL_W'(i))) begin
        dig_en[i] = ~ACTIVE_LOW;
      end
    end
  end

endmodule
